// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory-stage arbiter: FSM state codes and the
// access-alignment check that the datapath's memory-stage decode also uses.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // An access is misaligned when it does not start on a word boundary, or
  // when its byte enables, placed at the byte offset, reach past the word.
  // Operands are widened to a fixed maximum so one function serves any width.
  function automatic logic access_misaligned(input logic [3:0]  off,
                                             input logic [15:0] be,
                                             input int          be_w);
    logic [31:0] span;
    span = 32'(be) << off;
    return (off != 4'd0) || ((span >> be_w) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Busy-cycle timer for the memory arbiter.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clear   : reload the count with zero
//   en      : count one busy cycle
//   expired : count has reached TIMEOUT-1
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge.
    if (rst || clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory-stage arbiter: merges instruction-fetch (if_*) and load/store (dm_*)
// requests onto a single-outstanding req/ack memory port, returning per-port
// one-cycle done pulses with registered read data and error flags.
//   clk, rst                 : clock, synchronous active-high reset
//   if_req_i, if_addr_i      : fetch request, held until if_done_o
//   if_done_o/rdata_o/err_o  : fetch completion, word, error (misalign/timeout)
//   dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i : load/store request
//   dm_done_o/rdata_o/err_o  : load/store completion, data, error
//   mem_req_o..mem_be_o      : memory request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i   : memory completion, read data same cycle
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 16,
  parameter int MAX_D_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_done_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_err_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  output logic                dm_done_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W    = DATA_W / 8;
  localparam int OFF_W   = (BE_W > 1) ? $clog2(BE_W) : 1;
  localparam int BURST_W = $clog2(MAX_D_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);

  state_t             state;
  logic [BURST_W-1:0] burst_cnt;
  logic               busy;
  logic               expired;
  logic               grant_d;
  logic               if_mis;
  logic               dm_mis;

  assign busy = (state == ST_BUSY_I) || (state == ST_BUSY_D);

  // Data normally wins; a pending fetch takes over once MAX_D_BURST data
  // grants in a row have gone by while it waited.
  assign grant_d = dm_req_i && !(if_req_i && (burst_cnt == BURST_MAX));

  assign if_mis = access_misaligned(4'(if_addr_i[OFF_W-1:0]), 16'({BE_W{1'b1}}), BE_W);
  assign dm_mis = access_misaligned(4'(dm_addr_i[OFF_W-1:0]), 16'(dm_be_i), BE_W);

  // Timer runs only while a memory access is outstanding.
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy),
    .en      (busy),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      burst_cnt   <= '0;
      if_done_o   <= 1'b0;
      if_rdata_o  <= '0;
      if_err_o    <= 1'b0;
      dm_done_o   <= 1'b0;
      dm_rdata_o  <= '0;
      dm_err_o    <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      if_done_o <= 1'b0;
      dm_done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant_d) begin
            // Count data grants only while a fetch is actually waiting.
            if (!if_req_i)                   burst_cnt <= '0;
            else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + BURST_W'(1);
            if (dm_mis) begin
              dm_done_o  <= 1'b1;
              dm_err_o   <= 1'b1;
              dm_rdata_o <= '0;
              state      <= ST_RESP;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= dm_we_i;
              mem_addr_o  <= {dm_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wdata_o <= dm_wdata_i;
              mem_be_o    <= dm_be_i;
              state       <= ST_BUSY_D;
            end
          end else if (if_req_i) begin
            burst_cnt <= '0;
            if (if_mis) begin
              if_done_o  <= 1'b1;
              if_err_o   <= 1'b1;
              if_rdata_o <= '0;
              state      <= ST_RESP;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= {if_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wdata_o <= '0;
              mem_be_o    <= '1;
              state       <= ST_BUSY_I;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // An ack in the final timer cycle still counts as a normal completion.
          if (mem_ack_i || expired) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            state     <= ST_RESP;
            if (state == ST_BUSY_D) begin
              dm_done_o  <= 1'b1;
              dm_err_o   <= !mem_ack_i;
              dm_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
            end else begin
              if_done_o  <= 1'b1;
              if_err_o   <= !mem_ack_i;
              if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter. A transaction-level reference model
// predicts, from the arbitration rules and handshake latencies, which port
// is granted, the busy window on the memory port, the done cycle and the
// returned data/error. Requesters and the memory responder are driven from
// the same model so ack timing is known exactly.
module tb_mem_bus_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT     = 16;
  localparam int MAX_D_BURST = 4;
  localparam int NEVER       = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_done_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [3:0]  dm_be_i = '0;
  logic        dm_done_o;
  logic [31:0] dm_rdata_o;
  logic        dm_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .MAX_D_BURST(MAX_D_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_done_o(if_done_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i),
    .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // Stimulus controls
  bit in_rst = 1'b1;
  bit gen_en = 1'b1;
  bit force_timeout = 1'b0;
  int if_pct = 30, dm_pct = 30, mis_pct = 10, to_pct = 5;

  // Requesters
  bit          if_act = 1'b0, dm_act = 1'b0;
  int          if_done_at = NEVER, dm_done_at = NEVER;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = '0;

  // Reference model: arbiter availability, burst count, current transaction
  int          free_at = NEVER;
  int          burst = 0;
  bit          t_is_d = 1'b0, t_err = 1'b0, t_we = 1'b0;
  int          t_done = -10, t_busy_s = -10, t_busy_e = -11, t_ack = -10;
  logic [31:0] t_rd = '0, t_addr = '0, t_wdata = '0;
  logic [3:0]  t_be = '0;
  logic [31:0] exp_if_rd = '0, exp_dm_rd = '0;
  bit          exp_if_err = 1'b0, exp_dm_err = 1'b0;
  bit          zero_expected = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic reset_model();
    if_act = 1'b0; dm_act = 1'b0;
    if_done_at = NEVER; dm_done_at = NEVER;
    burst = 0;
    t_done = -10; t_busy_s = -10; t_busy_e = -11; t_ack = -10;
    exp_if_rd = '0; exp_dm_rd = '0; exp_if_err = 1'b0; exp_dm_err = 1'b0;
    force_timeout = 1'b0;
    free_at = cyc + 1;
  endtask

  // Grant decided in IDLE cycle `cyc`: predict the whole transaction.
  task automatic grant(input bit is_d);
    int d;
    bit mis;
    if (is_d) mis = (dm_addr[1:0] != 2'b00) || ((int'(dm_be) << dm_addr[1:0]) > 15);
    else      mis = (if_addr[1:0] != 2'b00);
    t_is_d  = is_d;
    t_addr  = (is_d ? dm_addr : if_addr) & ~32'h3;
    t_we    = is_d && dm_we;
    t_be    = is_d ? dm_be : 4'hF;
    t_wdata = dm_wdata;
    if (mis) begin
      t_done = cyc + 1; t_busy_s = -10; t_busy_e = -11; t_ack = -10;
      t_err = 1'b1; t_rd = '0;
    end else begin
      if (force_timeout)                    d = TIMEOUT;
      else if ($urandom_range(99) < to_pct) d = TIMEOUT;
      else if ($urandom_range(9) == 0)      d = TIMEOUT - 1;
      else                                  d = $urandom_range(3);
      t_busy_s = cyc + 1;
      if (d < TIMEOUT) begin
        t_ack = cyc + 1 + d; t_done = cyc + 2 + d; t_err = 1'b0; t_rd = $urandom;
      end else begin
        t_ack = -10; t_done = cyc + 1 + TIMEOUT; t_err = 1'b1; t_rd = '0;
      end
      t_busy_e = t_done - 1;
    end
    free_at = t_done + 1;
    if (is_d) dm_done_at = t_done;
    else      if_done_at = t_done;
  endtask

  task automatic step();
    bit in_busy;
    @(posedge clk);
    #1;
    cyc++;
    if (if_act && cyc > if_done_at) if_act = 1'b0;
    if (dm_act && cyc > dm_done_at) dm_act = 1'b0;
    if (!in_rst && gen_en && !if_act && $urandom_range(99) < if_pct) begin
      if_act = 1'b1; if_done_at = NEVER;
      if_addr = 32'h0000_1000 + 32'($urandom_range(255)) * 4;
      if ($urandom_range(99) < mis_pct) if_addr += 32'($urandom_range(3, 1));
    end
    if (!in_rst && gen_en && !dm_act && $urandom_range(99) < dm_pct) begin
      dm_act = 1'b1; dm_done_at = NEVER;
      dm_addr = 32'h0000_8000 + 32'($urandom_range(255)) * 4;
      if ($urandom_range(99) < mis_pct) dm_addr += 32'($urandom_range(3, 1));
      dm_we = 1'($urandom_range(1));
      dm_be = 4'($urandom_range(15, 1));
      dm_wdata = $urandom;
    end
    rst = in_rst;
    if_req_i = if_act; if_addr_i = if_addr;
    dm_req_i = dm_act; dm_we_i = dm_we; dm_addr_i = dm_addr;
    dm_wdata_i = dm_wdata; dm_be_i = dm_be;

    if (!in_rst && cyc == free_at) begin
      if (dm_act && !(if_act && burst == MAX_D_BURST)) begin
        burst = if_act ? ((burst < MAX_D_BURST) ? burst + 1 : burst) : 0;
        grant(1'b1);
      end else if (if_act) begin
        burst = 0;
        grant(1'b0);
      end else begin
        free_at = cyc + 1;
      end
    end

    // Memory responder; stray acks outside the busy window must be ignored.
    in_busy = (cyc >= t_busy_s) && (cyc <= t_busy_e);
    mem_ack_i   = in_busy ? (cyc == t_ack) : ($urandom_range(3) == 0);
    mem_rdata_i = (cyc == t_ack) ? t_rd : $urandom;

    @(negedge clk);
    if (cyc == t_done) begin
      if (t_is_d) begin exp_dm_rd = t_rd; exp_dm_err = t_err; end
      else        begin exp_if_rd = t_rd; exp_if_err = t_err; end
    end
    check("if_done", if_done_o, (cyc == t_done) && !t_is_d);
    check("dm_done", dm_done_o, (cyc == t_done) && t_is_d);
    check("mem_req", mem_req_o, in_busy);
    if (in_busy) begin
      check("mem_we",   mem_we_o,   t_we);
      check("mem_addr", mem_addr_o, t_addr);
      check("mem_be",   mem_be_o,   t_be);
      if (t_we) check("mem_wdata", mem_wdata_o, t_wdata);
    end
    check("if_rdata", if_rdata_o, exp_if_rd);
    check("if_err",   if_err_o,   exp_if_err);
    check("dm_rdata", dm_rdata_o, exp_dm_rd);
    check("dm_err",   dm_err_o,   exp_dm_err);
    if (zero_expected) begin
      check("rst_mem_we",    mem_we_o,    1'b0);
      check("rst_mem_addr",  mem_addr_o,  32'h0);
      check("rst_mem_wdata", mem_wdata_o, 32'h0);
      check("rst_mem_be",    mem_be_o,    4'h0);
    end
    zero_expected = in_rst;
    if (in_rst) reset_model();
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    in_rst = 1'b0;

    // Mixed traffic with misaligned accesses, timeouts and stray acks
    repeat (1500) step();

    // Both ports saturated: fetch must get in after every MAX_D_BURST data grants
    if_pct = 100; dm_pct = 100; mis_pct = 0; to_pct = 0;
    repeat (600) step();

    // Heavier timeout mix
    if_pct = 40; dm_pct = 40; mis_pct = 10; to_pct = 30;
    repeat (800) step();

    // Reset during the third busy cycle of a load that is never acked
    gen_en = 1'b0;
    for (int i = 0; i < 100 && (if_act || dm_act || cyc <= t_done); i++) step();
    check("drain_idle", (if_act || dm_act) ? 1'b1 : 1'b0, 1'b0);
    dm_act = 1'b1; dm_done_at = NEVER;
    dm_addr = 32'h0000_0300; dm_we = 1'b0; dm_be = 4'hF; dm_wdata = '0;
    force_timeout = 1'b1;
    step();
    step();
    step();
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
